// File: rtl/parity_rr_scheduler_pkg.sv
// Shared encodings for the parity round-robin scheduler: output-stage states,
// requester source IDs and parity modes.
package parity_rr_scheduler_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic SRC_A    = 1'b0;
    localparam logic SRC_B    = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_rr_scheduler_parity_gen.sv
// Combinational framer: appends a parity bit so the 8-bit frame carries an
// even (mode 0) or odd (mode 1) number of ones.
module parity_gen (
    input  logic [6:0] i_data,
    input  logic       i_mode,
    output logic [7:0] o_frame
);

    logic w_par;

    assign w_par   = (^i_data) ^ i_mode;
    assign o_frame = {i_data, w_par};

endmodule

// File: rtl/parity_rr_scheduler.sv
// Two-requester round-robin scheduler feeding a single-entry output register
// with parity framing; the slot refills on the same cycle it drains.
module parity_rr_scheduler
    import parity_rr_scheduler_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a_valid,
    input  logic [6:0]       req_a_data,
    input  logic             req_a_odd,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [6:0]       req_b_data,
    input  logic             req_b_odd,
    output logic             req_b_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b
);

    state_e           r_state;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_src;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic       w_slot_free;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_accept;
    logic       w_sel;
    logic [6:0] w_data;
    logic       w_mode;
    logic [7:0] w_frame;

    // On a tie the requester that did not win last time takes the slot.
    assign w_slot_free = (r_state == EMPTY) || out_ready;
    assign w_grant_a   = req_a_valid && (!req_b_valid || (r_last == SRC_B));
    assign w_grant_b   = req_b_valid && (!req_a_valid || (r_last == SRC_A));
    assign req_a_ready = w_grant_a && w_slot_free;
    assign req_b_ready = w_grant_b && w_slot_free;
    assign w_accept    = req_a_ready || req_b_ready;

    assign w_sel  = req_b_ready ? SRC_B : SRC_A;
    assign w_data = req_b_ready ? req_b_data : req_a_data;
    assign w_mode = req_b_ready ? req_b_odd  : req_a_odd;

    parity_gen u_parity_gen (
        .i_data  (w_data),
        .i_mode  (w_mode),
        .o_frame (w_frame)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_src   <= SRC_A;
            r_last      <= SRC_B;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready && !w_accept) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
            if (w_accept) begin
                r_out_data <= w_frame;
                r_out_src  <= w_sel;
                r_last     <= w_sel;
                if (w_sel == SRC_B) r_cnt_b <= r_cnt_b + 1'b1;
                else                r_cnt_a <= r_cnt_a + 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_src     = r_out_src;
    assign grant_cnt_a = r_cnt_a;
    assign grant_cnt_b = r_cnt_b;

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Directed bench for parity_rr_scheduler: hand-computed frames, sources and
// counter values per scenario.
module tb_parity_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a_valid, req_a_odd, req_b_valid, req_b_odd;
    logic [6:0] req_a_data, req_b_data;
    logic       req_a_ready, req_b_ready;
    logic       out_valid, out_src, out_ready;
    logic [7:0] out_data;
    logic [7:0] grant_cnt_a, grant_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    parity_rr_scheduler #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a_valid (req_a_valid),
        .req_a_data  (req_a_data),
        .req_a_odd   (req_a_odd),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_data  (req_b_data),
        .req_b_odd   (req_b_odd),
        .req_b_ready (req_b_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_a_valid = 1'b0; req_a_data = 7'h00; req_a_odd = 1'b0;
        req_b_valid = 1'b0; req_b_data = 7'h00; req_b_odd = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, out_data, out_src} !== {1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset_out: got v=%b d=%h s=%b want v=0 d=00 s=0", out_valid, out_data, out_src);
            n_fail++;
        end
        n_checks++;
        if ({grant_cnt_a, grant_cnt_b} !== 16'h0000) begin
            $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", grant_cnt_a, grant_cnt_b);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_a;
        req_a_valid = 1'b1; req_a_data = 7'b1010101; req_a_odd = 1'b0;
        #1;
        n_checks++;
        if ({req_a_ready, req_b_ready} !== 2'b10) begin
            $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", req_a_ready, req_b_ready);
            n_fail++;
        end
        step();
        req_a_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_data, out_src, grant_cnt_a} !== {1'b1, 8'b10101010, 1'b0, 8'd1}) begin
            $display("FAIL single_even: got v=%b d=%b s=%b cnt=%0d want v=1 d=10101010 s=0 cnt=1",
                     out_valid, out_data, out_src, grant_cnt_a);
            n_fail++;
        end
        req_a_valid = 1'b1; req_a_odd = 1'b1;
        step();
        req_a_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_data, grant_cnt_a} !== {1'b1, 8'b10101011, 8'd2}) begin
            $display("FAIL single_odd: got v=%b d=%b cnt=%0d want v=1 d=10101011 cnt=2",
                     out_valid, out_data, grant_cnt_a);
            n_fail++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL drain_empty: got v=%b want v=0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_alternate;
        logic       es;
        logic [7:0] ed;
        do_reset();
        req_a_valid = 1'b1; req_a_data = 7'h11; req_a_odd = 1'b0;
        req_b_valid = 1'b1; req_b_data = 7'h22; req_b_odd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            es = (i % 2 == 1);
            ed = es ? 8'h45 : 8'h22;
            #1;
            n_checks++;
            if ({req_a_ready, req_b_ready} !== {~es, es}) begin
                $display("FAIL alt_ready[%0d]: got a=%b b=%b want a=%b b=%b", i, req_a_ready, req_b_ready, ~es, es);
                n_fail++;
            end
            step();
            n_checks++;
            if ({out_valid, out_src, out_data, grant_cnt_a, grant_cnt_b} !==
                {1'b1, es, ed, 8'(i / 2 + 1), 8'((i + 1) / 2)}) begin
                $display("FAIL alt_out[%0d]: got v=%b s=%b d=%h a=%0d b=%0d want v=1 s=%b d=%h a=%0d b=%0d",
                         i, out_valid, out_src, out_data, grant_cnt_a, grant_cnt_b,
                         es, ed, i / 2 + 1, (i + 1) / 2);
                n_fail++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall;
        // Last winner is B with counts a=2 b=2, so a lone A loads 8'hAA.
        req_a_valid = 1'b1; req_a_data = 7'b1010101; req_a_odd = 1'b0;
        step();
        n_checks++;
        if ({out_valid, out_data, out_src, grant_cnt_a, grant_cnt_b} !== {1'b1, 8'hAA, 1'b0, 8'd3, 8'd2}) begin
            $display("FAIL stall_load: got v=%b d=%h s=%b a=%0d b=%0d want v=1 d=aa s=0 a=3 b=2",
                     out_valid, out_data, out_src, grant_cnt_a, grant_cnt_b);
            n_fail++;
        end
        out_ready = 1'b0;
        req_b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a_data = 7'(i + 3); req_a_odd = i[0];
            req_b_data = 7'(i + 9); req_b_odd = ~i[0];
            #1;
            n_checks++;
            if ({req_a_ready, req_b_ready} !== 2'b00) begin
                $display("FAIL stall_ready[%0d]: got a=%b b=%b want 0 0", i, req_a_ready, req_b_ready);
                n_fail++;
            end
            step();
            n_checks++;
            if ({out_valid, out_data, out_src, grant_cnt_a, grant_cnt_b} !== {1'b1, 8'hAA, 1'b0, 8'd3, 8'd2}) begin
                $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%b a=%0d b=%0d want v=1 d=aa s=0 a=3 b=2",
                         i, out_valid, out_data, out_src, grant_cnt_a, grant_cnt_b);
                n_fail++;
            end
        end
        // Pointer stayed on A, so releasing the stall hands the tie to B.
        out_ready = 1'b1;
        req_b_data = 7'h01; req_b_odd = 1'b0;
        #1;
        n_checks++;
        if ({req_a_ready, req_b_ready} !== 2'b01) begin
            $display("FAIL stall_release: got a=%b b=%b want a=0 b=1", req_a_ready, req_b_ready);
            n_fail++;
        end
        step();
        n_checks++;
        if ({out_src, out_data, grant_cnt_b} !== {1'b1, 8'h03, 8'd3}) begin
            $display("FAIL stall_next: got s=%b d=%h b=%0d want s=1 d=03 b=3", out_src, out_data, grant_cnt_b);
            n_fail++;
        end
        idle_inputs();
    endtask

    task automatic test_only_b;
        do_reset();
        req_b_valid = 1'b1; req_b_data = 7'h7F; req_b_odd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (req_b_ready !== 1'b1) begin
                $display("FAIL onlyb_ready[%0d]: got %b want 1", i, req_b_ready);
                n_fail++;
            end
            step();
            n_checks++;
            if ({out_valid, out_src, out_data, grant_cnt_b} !== {1'b1, 1'b1, 8'hFF, 8'(i + 1)}) begin
                $display("FAIL onlyb_out[%0d]: got v=%b s=%b d=%h b=%0d want v=1 s=1 d=ff b=%0d",
                         i, out_valid, out_src, out_data, grant_cnt_b, i + 1);
                n_fail++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap;
        do_reset();
        req_a_valid = 1'b1; req_a_data = 7'h00; req_a_odd = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) begin
                n_checks++;
                if (grant_cnt_a !== 8'd255) begin
                    $display("FAIL wrap_255: got %0d want 255", grant_cnt_a);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if ({grant_cnt_a, out_data} !== {8'd0, 8'h01}) begin
            $display("FAIL wrap_zero: got cnt=%0d d=%h want cnt=0 d=01", grant_cnt_a, out_data);
            n_fail++;
        end
        step();
        req_a_valid = 1'b0;
        n_checks++;
        if (grant_cnt_a !== 8'd1) begin
            $display("FAIL wrap_one: got %0d want 1", grant_cnt_a);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        // Slot is FULL with cnt_a=1 here; reset lands between edges.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, grant_cnt_a, grant_cnt_b} !== {1'b0, 8'h00, 8'd0, 8'd0}) begin
            $display("FAIL rstmid_clear: got v=%b d=%h a=%0d b=%0d want v=0 d=00 a=0 b=0",
                     out_valid, out_data, grant_cnt_a, grant_cnt_b);
            n_fail++;
        end
        #1 rst_n = 1'b1;
        req_a_valid = 1'b1; req_a_data = 7'h01; req_a_odd = 1'b0;
        req_b_valid = 1'b1; req_b_data = 7'h02; req_b_odd = 1'b0;
        #1;
        n_checks++;
        if ({req_a_ready, req_b_ready} !== 2'b10) begin
            $display("FAIL rstmid_tie: got a=%b b=%b want a=1 b=0", req_a_ready, req_b_ready);
            n_fail++;
        end
        step();
        n_checks++;
        if ({out_valid, out_src, out_data, grant_cnt_a, grant_cnt_b} !== {1'b1, 1'b0, 8'h03, 8'd1, 8'd0}) begin
            $display("FAIL rstmid_first: got v=%b s=%b d=%h a=%0d b=%0d want v=1 s=0 d=03 a=1 b=0",
                     out_valid, out_src, out_data, grant_cnt_a, grant_cnt_b);
            n_fail++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_alternate();
        test_stall();
        test_only_b();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
